fp_mul_result_pack: RTL
=======================

Name: fp_mul_result_pack

Overview:
- Output stage directly downstream of the single-precision multiplier datapath.
- Accepts the multiplier's sign, exponent, 24-bit significand, rounding mode and the invalid/overflow/underflow/inexact/zero flags.
- Resolves special cases and packs an IEEE-754 binary32 word into a small result FIFO with valid/ready handshake.
- Maintains sticky exception flags for the FPU status register.

Parameters:
- FIFO_DEPTH, 2, result FIFO entries; power of two, >= 2.
- QNAN_VAL, 32'h7FC00000, canonical quiet NaN emitted on invalid.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-low reset
- in_valid  input  1  multiplier result present
- in_ready  output  1  stage can accept a result
- Sz  input  1  result sign
- Ez  input  8  biased result exponent
- Mz  input  24  normalised rounded significand; bit 23 = hidden bit
- R_mode  input  2  00 RNE, 01 RZ, 10 RUP (+inf), 11 RDN (-inf)
- invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag  input  1 each  multiplier flags
- out_valid  output  1  packed result available
- out_ready  input  1  consumer accepts result
- result  output  32  binary32 word
- result_flags  output  5  {NV,OF,UF,NX,ZR} of the result at FIFO head
- sticky_flags  output  5  accumulated {NV,OF,UF,NX,ZR}
- flags_clr  input  1  synchronous clear of sticky_flags

Behaviour:
- Reset (RST=0, asynchronous): FIFO empty, out_valid=0, result=0, result_flags=0, sticky_flags=0, in_ready=1 once RST deasserts.
- Push when in_valid&&in_ready. Pop when out_valid&&out_ready.
- Latency: a pushed result reaches the head with out_valid=1 on the next rising edge if the FIFO was empty. No combinational in->out path.
- in_ready = (count != FIFO_DEPTH); depends on registered count only.
  - When full, a push is not accepted even if a pop happens in the same cycle.
- Simultaneous push and pop when not full or empty: count unchanged, order preserved.
- Pop when empty and push when full are impossible by handshake; if forced, ignored.
- Pointers wrap modulo FIFO_DEPTH.
- result, result_flags: registered head entry. They hold stable while out_valid=1 and out_ready=0.
- Packing priority, computed at push:
  1. invalid_flag -> QNAN_VAL (sign ignored).
  2. overflow_flag -> infinity {Sz,8'hFF,23'h0} when R_mode=RNE, RUP with Sz=0, or RDN with Sz=1. Otherwise max finite {Sz,8'hFE,23'h7FFFFF}.
  3. zero_flag or underflow_flag -> signed zero {Sz,31'h0}; flush-to-zero, no denormals.
  4. Otherwise {Sz,Ez,Mz[22:0]}. If Ez==8'hFF here, treat as overflow per rule 2 and set the OF bit.
- Stored flags = the input flags, with NX forced to 1 on overflow or underflow.
- sticky_flags update on each push: sticky <= (flags_clr ? 0 : sticky) | pushed_flags.
  - A clear and a push in the same cycle keep only the new flags.
- Reset mid-operation: FIFO contents discarded, all outputs return to their reset values immediately.

Optional Feature:
- FP_MUL_PACK_CNT_EN defined:
  - Adds output result_cnt, 16 bits: count of pops.
  - Saturates at 16'hFFFF.
  - Reset to 0; cleared by flags_clr. A clear and a pop in the same cycle give 1.
- FP_MUL_PACK_CNT_EN undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Normal case: push Sz=0, Ez=8'h80, Mz=24'hC00000, no flags, out_ready=1 -> next cycle out_valid=1, result=32'h40400000 (3.0), result_flags=0.
- Invalid: push invalid_flag=1, Sz=1 -> result=32'h7FC00000, sticky_flags[4]=1, and the bit persists until flags_clr.
- Overflow by mode, all with Sz=0:
  - R_mode=RNE -> 32'h7F800000.
  - R_mode=RZ -> 32'h7F7FFFFF; flags OF=1, NX=1.
  - Repeat with Sz=1 and R_mode=RUP -> 32'hFF7FFFFF.
- Backpressure: out_ready=0, three pushes with FIFO_DEPTH=2 -> in_ready=0 after the second push, the third is held. Raise out_ready -> results emerge in order, with no loss or duplication.
- Underflow: underflow_flag=1, Sz=1 -> 32'h80000000, flags UF=1, NX=1. Same cycle flags_clr=1 with sticky previously 5'b10000 -> sticky=5'b00110.
- Reset: assert RST mid-stream with two entries queued -> out_valid=0, sticky_flags=0 immediately. After release, the first new push is output correctly.

Source files
------------

// File: rtl/fp_mul_result_pack.sv
// fp_mul_result_pack: output stage of the single-precision multiplier.
// Resolves special cases (NaN, overflow by rounding mode, flush-to-zero),
// packs a binary32 word plus its exception flags into a small FIFO with a
// valid/ready handshake, and keeps sticky exception flags for the FPU status
// register.
// Optional feature: define FP_MUL_PACK_CNT_EN to add the 16-bit saturating
// pop counter output result_cnt (cleared by flags_clr).
module fp_mul_result_pack #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] QNAN_VAL   = 32'h7FC00000
) (
  input  logic        CLK,
  input  logic        RST,
  // Upstream handshake and multiplier result
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        Sz,
  input  logic [7:0]  Ez,
  input  logic [23:0] Mz,
  input  logic [1:0]  R_mode,
  input  logic        invalid_flag,
  input  logic        overflow_flag,
  input  logic        underflow_flag,
  input  logic        inexact_flag,
  input  logic        zero_flag,
  // Downstream handshake and packed result
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  result_flags,
  // Status register interface
  output logic [4:0]  sticky_flags,
  input  logic        flags_clr
`ifdef FP_MUL_PACK_CNT_EN
  ,
  output logic [15:0] result_cnt
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] RmRne = 2'b00;
  localparam logic [1:0] RmRup = 2'b10;
  localparam logic [1:0] RmRdn = 2'b11;

  typedef struct packed {
    logic [31:0] word;
    logic [4:0]  flags;  // {NV, OF, UF, NX, ZR}
  } entry_t;

  // Hidden bit is implied by the packed format and never stored.
  logic unused_hidden_bit;
  assign unused_hidden_bit = Mz[23];

  // ---------------------------------------------------------------------------
  // Result packing
  // ---------------------------------------------------------------------------
  logic   special_zero;
  logic   of_eff;
  logic   round_to_inf;
  entry_t pack_entry;

  // Resolve special cases in priority order: NaN, overflow, zero, normal.
  always_comb begin
    special_zero = zero_flag | underflow_flag;
    // An all-ones exponent reaching the normal path is an overflow the
    // multiplier did not flag.
    of_eff       = overflow_flag |
                   (~invalid_flag & ~special_zero & (Ez == 8'hFF));
    round_to_inf = (R_mode == RmRne) ||
                   ((R_mode == RmRup) && !Sz) ||
                   ((R_mode == RmRdn) && Sz);

    pack_entry.word = {Sz, Ez, Mz[22:0]};
    if (invalid_flag) begin
      pack_entry.word = QNAN_VAL;
    end else if (of_eff) begin
      pack_entry.word = round_to_inf ? {Sz, 8'hFF, 23'h000000} : {Sz, 8'hFE, 23'h7FFFFF};
    end else if (special_zero) begin
      pack_entry.word = {Sz, 31'h00000000};
    end

    pack_entry.flags = {invalid_flag,
                        of_eff,
                        underflow_flag,
                        inexact_flag | of_eff | underflow_flag,
                        zero_flag};
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   fill_q, fill_d;
  logic              push;
  logic              pop;

  // Handshake decode; ready and valid come from the registered fill level only.
  always_comb begin
    in_ready  = (fill_q != CntW'(FIFO_DEPTH));
    out_valid = (fill_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // FIFO next state: storage write, pointer advance and fill level.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;

    if (push) begin
      mem_d[wr_ptr_q] = pack_entry;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   fill_d = fill_q + CntW'(1);
      2'b01:   fill_d = fill_q - CntW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // FIFO state registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Head entry drives the outputs straight from registers.
  always_comb begin
    result       = mem_q[rd_ptr_q].word;
    result_flags = mem_q[rd_ptr_q].flags;
  end

  // ---------------------------------------------------------------------------
  // Sticky exception flags
  // ---------------------------------------------------------------------------
  logic [4:0] sticky_q, sticky_d;

  // Clear applies first so a same-cycle clear and push keeps only the new flags.
  always_comb begin
    sticky_d = flags_clr ? 5'b00000 : sticky_q;
    if (push) begin
      sticky_d = sticky_d | pack_entry.flags;
    end
  end

  // Sticky flag register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;

`ifdef FP_MUL_PACK_CNT_EN
  // ---------------------------------------------------------------------------
  // Pop counter
  // ---------------------------------------------------------------------------
  logic [15:0] pop_cnt_q, pop_cnt_d;

  // Saturating pop count; a clear with a pop in the same cycle yields one.
  always_comb begin
    pop_cnt_d = flags_clr ? 16'h0000 : pop_cnt_q;
    if (pop && (pop_cnt_d != 16'hFFFF)) begin
      pop_cnt_d = pop_cnt_d + 16'h0001;
    end
  end

  // Pop counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pop_cnt_q <= '0;
    end else begin
      pop_cnt_q <= pop_cnt_d;
    end
  end

  assign result_cnt = pop_cnt_q;
`endif

endmodule
